// File: rtl/dvp_pixel_capture_pkg.sv
// Shared state type and geometry helpers for the DVP capture front end.
// Geometry is per-instance, so the derived sizes are functions evaluated by the top.
package dvp_cap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_ACTIVE
   } cap_state_t;

   // Output dimension after 2^s decimation.
   function automatic int out_dim(input int n, input int s);
      return n >> s;
   endfunction

   // Bits needed for a counter that must be able to hold max_val itself.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dvp_pixel_capture_byte_pair.sv
// Pairs consecutive DVP bytes within a line into 16-bit pixels.
// The strobe fires combinationally on the cycle that presents the second byte.
module dvp_byte_pair (
   input  logic        pclk,
   input  logic        reset,
   input  logic        i_href,
   input  logic [7:0]  i_d,
   output logic        o_pix_vld,
   output logic [15:0] o_pix,
   output logic        o_phase
);

   logic       r_phase;
   logic [7:0] r_hi;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_phase <= 1'b0;
         r_hi    <= '0;
      end else if (!i_href) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         if (!r_phase) r_hi <= i_d;
      end
   end

   assign o_pix_vld = i_href & r_phase;
   assign o_pix     = {r_hi, i_d};
   assign o_phase   = r_phase;

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP capture: frames on VSYNC/HREF, decimates, generates linear frame-buffer
// writes and reports per-frame geometry errors.
module dvp_pixel_capture
   import dvp_cap_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int DECIM_SHIFT = 0,
   parameter int ADDR_W      = 19
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   input  logic              enable,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              frame_done,
   output logic              frame_err,
   output logic [7:0]        frame_cnt,
   output logic              busy
);

   localparam int OUT_W      = out_dim(H_ACTIVE, DECIM_SHIFT);
   localparam int OUT_H      = out_dim(V_ACTIVE, DECIM_SHIFT);
   localparam int OUT_PIXELS = OUT_W * OUT_H;
   localparam int XW         = cnt_w(H_ACTIVE);
   localparam int YW         = cnt_w(V_ACTIVE);
   localparam int CW         = ADDR_W + 1;

   localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE);
   localparam logic [XW-1:0] X_MASK  = XW'((1 << DECIM_SHIFT) - 1);
   localparam logic [YW-1:0] Y_MASK  = YW'((1 << DECIM_SHIFT) - 1);
   localparam logic [CW-1:0] PIX_MAX = CW'(OUT_PIXELS);

   cap_state_t r_state, w_state_nxt;

   logic              r_vsync_d, r_href_d;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [CW-1:0]     r_cnt;
   logic              r_err;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_wr_data;
   logic              r_frame_done, r_frame_err;
   logic [7:0]        r_frame_cnt;

   logic              w_pix_vld, w_phase;
   logic [15:0]       w_pix;
   logic              w_vs_rise, w_vs_fall, w_href_fall, w_active;
   logic              w_in_x, w_in_y, w_decim_ok, w_wr;
   logic              w_pix_err, w_line_err, w_eof, w_eof_err;
   logic [YW-1:0]     w_y_nxt;

   dvp_byte_pair u_pair (
      .pclk      (pclk),
      .reset     (reset),
      .i_href    (href),
      .i_d       (d),
      .o_pix_vld (w_pix_vld),
      .o_pix     (w_pix),
      .o_phase   (w_phase)
   );

   assign w_vs_rise   = vsync & ~r_vsync_d;
   assign w_vs_fall   = ~vsync & r_vsync_d;
   assign w_href_fall = ~href & r_href_d;
   assign w_active    = (r_state == ST_ACTIVE);

   assign w_in_x      = (r_x < X_MAX);
   assign w_in_y      = (r_y < Y_MAX);
   assign w_decim_ok  = ((r_x & X_MASK) == '0) && ((r_y & Y_MASK) == '0);
   assign w_wr        = w_active & w_pix_vld & w_in_x & w_in_y & w_decim_ok
                        & (r_cnt < PIX_MAX);
   assign w_pix_err   = w_active & w_pix_vld & ~(w_in_x & w_in_y);
   assign w_line_err  = w_active & w_href_fall & ((r_x != X_MAX) | w_phase);

   // y saturates at V_ACTIVE; surplus lines are caught by the pixel check.
   assign w_y_nxt     = (w_href_fall && w_in_y) ? r_y + YW'(1) : r_y;

   // A line ending in the same cycle as vsync rises is folded in first.
   assign w_eof       = w_active & w_vs_rise;
   assign w_eof_err   = r_err | w_pix_err | w_line_err | (w_y_nxt != Y_MAX) | href;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_vs_rise && enable) w_state_nxt = ST_SYNC;
         ST_SYNC:   if (w_vs_fall)           w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_vs_rise)           w_state_nxt = enable ? ST_SYNC : ST_IDLE;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_vsync_d <= 1'b0;
         r_href_d  <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_vsync_d <= vsync;
         r_href_d  <= href;
         if (r_state == ST_SYNC) begin
            r_x   <= '0;
            r_y   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_active) begin
            if (w_href_fall)             r_x <= '0;
            else if (w_pix_vld && w_in_x) r_x <= r_x + XW'(1);
            r_y <= w_y_nxt;
            if (w_wr)                     r_cnt <= r_cnt + CW'(1);
            if (w_pix_err || w_line_err) r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_wr_en      <= w_wr;
         r_frame_done <= w_eof;
         if (w_wr) begin
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= w_pix;
         end
         if (w_eof) begin
            r_frame_err <= w_eof_err;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign frame_done = r_frame_done;
   assign frame_err  = r_frame_err;
   assign frame_cnt  = r_frame_cnt;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Scoreboard bench: instance A is 4x3 undecimated, instance B is 8x4 with 2x decimation.
// Stimulus pushes expected writes/frame results; a forked monitor pops and compares.
module tb_dvp_pixel_capture;

   logic       pclk = 1'b0;
   logic       reset, vsync, href, en_a, en_b;
   logic [7:0] d;

   logic       wr_en_a, wr_en_b, fdone_a, fdone_b, ferr_a, ferr_b, busy_a, busy_b;
   logic [7:0] wr_addr_a, wr_addr_b, fcnt_a, fcnt_b;
   logic [15:0] wr_data_a, wr_data_b;

   dvp_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(3), .DECIM_SHIFT(0), .ADDR_W(8)) u_a (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .enable(en_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .frame_done(fdone_a), .frame_err(ferr_a), .frame_cnt(fcnt_a), .busy(busy_a)
   );

   dvp_pixel_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM_SHIFT(1), .ADDR_W(8)) u_b (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .enable(en_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .frame_done(fdone_b), .frame_err(ferr_b), .frame_cnt(fcnt_b), .busy(busy_b)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic       err;
      logic [7:0] cnt;
   } fr_t;

   wr_t        qa[$], qb[$];
   fr_t        fa[$], fb[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] dbyte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event (value 0x%0h), expected none", name, act);
   endtask

   task automatic monitor();
      wr_t e;
      fr_t f;
      forever begin
         @(negedge pclk);
         if (wr_en_a) begin
            if (qa.size() == 0) unexpected("wr_a", 32'(wr_addr_a));
            else begin
               e = qa.pop_front();
               chk("wr_a_addr", 32'(wr_addr_a), 32'(e.addr));
               chk("wr_a_data", 32'(wr_data_a), 32'(e.data));
            end
         end
         if (wr_en_b) begin
            if (qb.size() == 0) unexpected("wr_b", 32'(wr_addr_b));
            else begin
               e = qb.pop_front();
               chk("wr_b_addr", 32'(wr_addr_b), 32'(e.addr));
               chk("wr_b_data", 32'(wr_data_b), 32'(e.data));
            end
         end
         if (fdone_a) begin
            if (fa.size() == 0) unexpected("fdone_a", 32'(fcnt_a));
            else begin
               f = fa.pop_front();
               chk("fdone_a_err", 32'(ferr_a), 32'(f.err));
               chk("fdone_a_cnt", 32'(fcnt_a), 32'(f.cnt));
            end
         end
         if (fdone_b) begin
            if (fb.size() == 0) unexpected("fdone_b", 32'(fcnt_b));
            else begin
               f = fb.pop_front();
               chk("fdone_b_err", 32'(ferr_b), 32'(f.err));
               chk("fdone_b_cnt", 32'(fcnt_b), 32'(f.cnt));
            end
         end
      end
   endtask

   task automatic exp_a(input int addr, input int b0);
      wr_t w;
      w.addr = 8'(addr);
      w.data = {8'(b0), 8'(b0 + 1)};
      qa.push_back(w);
   endtask

   task automatic exp_b(input int addr, input int b0);
      wr_t w;
      w.addr = 8'(addr);
      w.data = {8'(b0), 8'(b0 + 1)};
      qb.push_back(w);
   endtask

   task automatic exp_fa(input logic err, input logic [7:0] cnt);
      fr_t f;
      f.err = err;
      f.cnt = cnt;
      fa.push_back(f);
   endtask

   task automatic exp_fb(input logic err, input logic [7:0] cnt);
      fr_t f;
      f.err = err;
      f.cnt = cnt;
      fb.push_back(f);
   endtask

   task automatic cyc(input logic v, input logic h, input logic [7:0] dd);
      vsync = v;
      href  = h;
      d     = dd;
      @(negedge pclk);
   endtask

   task automatic vs_pulse();
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic line(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         cyc(1'b0, 1'b1, dbyte);
         dbyte++;
      end
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic exp_b_frame();
      int a;
      a = 0;
      for (int y = 0; y < 4; y += 2)
         for (int x = 0; x < 8; x += 2) begin
            exp_b(a, 16 * y + 2 * x);
            a++;
         end
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_wr_en"},   32'(wr_en_a),   32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr_a), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data_a), 32'd0);
      chk({tag, "_fdone"},   32'(fdone_a),   32'd0);
      chk({tag, "_ferr"},    32'(ferr_a),    32'd0);
      chk({tag, "_fcnt"},    32'(fcnt_a),    32'd0);
      chk({tag, "_busy"},    32'(busy_a),    32'd0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      reset = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00;
      en_a = 1'b0; en_b = 1'b0; dbyte = 8'h00;
      repeat (2) @(negedge pclk);

      chk_zero_a("rst_a");
      chk("rst_b_wr_en", 32'(wr_en_b), 32'd0);
      chk("rst_b_fcnt",  32'(fcnt_b),  32'd0);
      chk("rst_b_busy",  32'(busy_b),  32'd0);
      reset = 1'b0;
      @(negedge pclk);

      // A: clean 4x3 frame, bytes 0..23 -> pixels {2k,2k+1} at addr k
      en_a = 1'b1;
      vs_pulse();
      chk("t1_busy_a", 32'(busy_a), 32'd1);
      chk("t1_busy_b", 32'(busy_b), 32'd0);
      for (int k = 0; k < 12; k++) exp_a(k, 2 * k);
      dbyte = 8'h00;
      repeat (3) line(8);
      exp_fa(1'b0, 8'd1);
      vs_pulse();

      // A: odd line 1 drops byte 14; line 2 restarts pairing at byte 15
      for (int k = 0; k < 4; k++) exp_a(k, 2 * k);
      for (int k = 0; k < 3; k++) exp_a(4 + k, 8 + 2 * k);
      for (int k = 0; k < 4; k++) exp_a(7 + k, 15 + 2 * k);
      dbyte = 8'h00;
      line(8); line(7); line(8);
      exp_fa(1'b1, 8'd2);
      vs_pulse();

      // A: clean recovery frame; hand over to B at its closing vsync
      for (int k = 0; k < 12; k++) exp_a(k, 2 * k);
      dbyte = 8'h00;
      repeat (3) line(8);
      exp_fa(1'b0, 8'd3);
      en_a = 1'b0;
      en_b = 1'b1;
      vs_pulse();
      chk("t3_busy_a_idle", 32'(busy_a), 32'd0);

      // B: decimated frame, rows 0 and 2, even x only
      exp_b_frame();
      dbyte = 8'h00;
      repeat (2) line(16);
      chk("t4_busy_a", 32'(busy_a), 32'd0);
      chk("t4_busy_b", 32'(busy_b), 32'd1);
      repeat (2) line(16);
      exp_fb(1'b0, 8'd1);
      vs_pulse();

      // B: enable dropped mid-frame, frame still completes, then idle
      exp_b_frame();
      dbyte = 8'h00;
      repeat (2) line(16);
      en_b = 1'b0;
      repeat (2) line(16);
      exp_fb(1'b0, 8'd2);
      vs_pulse();
      chk("t5_busy_b_idle", 32'(busy_b), 32'd0);
      chk("t5_fcnt_b", 32'(fcnt_b), 32'd2);

      // A: 5 lines into a 3-line frame; writes stop after addr 11
      en_a = 1'b1;
      vs_pulse();
      for (int k = 0; k < 12; k++) exp_a(k, 2 * k);
      dbyte = 8'h00;
      repeat (5) line(8);
      exp_fa(1'b1, 8'd4);
      vs_pulse();

      // Reset mid-line after a single byte: no pixel completes, everything clears
      cyc(1'b0, 1'b1, 8'hA0);
      reset = 1'b1;
      cyc(1'b0, 1'b1, 8'hA1);
      chk_zero_a("midrst_a");
      chk("midrst_b_fcnt", 32'(fcnt_b), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'hA2 + i));
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      chk("postrst_busy_a", 32'(busy_a), 32'd0);

      // A: 256 clean frames wrap frame_cnt back to 0
      vs_pulse();
      for (int f = 1; f <= 256; f++) begin
         for (int k = 0; k < 12; k++) exp_a(k, 2 * k);
         dbyte = 8'h00;
         repeat (3) line(8);
         exp_fa(1'b0, 8'(f));
         if (f == 256) en_a = 1'b0;
         vs_pulse();
      end
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      chk("wrap_fcnt_a", 32'(fcnt_a), 32'd0);
      chk("wrap_ferr_a", 32'(ferr_a), 32'd0);
      chk("wrap_busy_a", 32'(busy_a), 32'd0);

      chk("qa_empty", 32'(qa.size()), 32'd0);
      chk("qb_empty", 32'(qb.size()), 32'd0);
      chk("fa_empty", 32'(fa.size()), 32'd0);
      chk("fb_empty", 32'(fb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
